// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared pipeline types and widths. The decoded control bundle
//                ctrl_t is used by both the decode control unit and the
//                decode/execute pipeline register.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int ALU_CTRL_W = 4;
    localparam int REG_AW     = 4;

    // Decoded control bundle carried from decode into execute
    typedef struct packed {
        logic                  imm_src;
        logic                  branch_flag;
        logic                  mem_write;
        logic                  mem_to_reg;
        logic [ALU_CTRL_W-1:0] alu_control;
    } ctrl_t;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/load_use_hazard.sv
`default_nettype none
// ============================================================================
//  Module      : load_use_hazard
//  Description : Combinational load-use detector. Flags when the instruction
//                in decode reads the destination of a load currently held in
//                the decode/execute register. Register 0 never hazards, and
//                rs2 is ignored when the immediate replaces it.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_use_hazard #(
    parameter int REG_AW = 4
) (
    input  logic              i_heldValid,
    input  logic              i_heldMemToReg,
    input  logic [REG_AW-1:0] i_heldRd,
    input  logic              i_inValid,
    input  logic [REG_AW-1:0] i_inRs1,
    input  logic [REG_AW-1:0] i_inRs2,
    input  logic              i_inImmSrc,
    output logic              o_hazard
);

    logic w_loadInFlight;
    logic w_rs1Match;
    logic w_rs2Match;

    // Source-register comparison against the in-flight load destination
    always_comb begin
        w_loadInFlight = i_heldValid && i_heldMemToReg && (i_heldRd != '0);
        w_rs1Match     = (i_inRs1 == i_heldRd);
        w_rs2Match     = (i_inRs2 == i_heldRd) && !i_inImmSrc;
        o_hazard       = w_loadInFlight && i_inValid && (w_rs1Match || w_rs2Match);
    end

endmodule : load_use_hazard
`default_nettype wire

// File: rtl/decode_execute_stage.sv
`default_nettype none
// ============================================================================
//  Module      : decode_execute_stage
//  Description : Decode -> execute pipeline register with valid/ready
//                handshake, branch flush and single-bubble load-use stall.
//                Optional feature macro: DECODE_EXECUTE_STAGE_PERF_CNT_EN adds
//                saturating 16-bit stall/bubble/flush counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_execute_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = pipe_pkg::REG_AW
) (
    input  logic                  clk,
    input  logic                  rst,
    // decode side
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_imm_src,
    input  logic                  in_branch_flag,
    input  logic                  in_mem_write,
    input  logic                  in_mem_to_reg,
    input  logic [ALU_CTRL_W-1:0] in_alu_control,
    input  logic [REG_AW-1:0]     in_rs1,
    input  logic [REG_AW-1:0]     in_rs2,
    input  logic [REG_AW-1:0]     in_rd,
    input  logic [DATA_W-1:0]     in_rs1_data,
    input  logic [DATA_W-1:0]     in_rs2_data,
    input  logic [DATA_W-1:0]     in_imm,
    input  logic [DATA_W-1:0]     in_pc,
    input  logic                  flush,
    // execute side
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_imm_src,
    output logic                  out_branch_flag,
    output logic                  out_mem_write,
    output logic                  out_mem_to_reg,
    output logic [ALU_CTRL_W-1:0] out_alu_control,
    output logic [REG_AW-1:0]     out_rs1,
    output logic [REG_AW-1:0]     out_rs2,
    output logic [REG_AW-1:0]     out_rd,
    output logic [DATA_W-1:0]     out_rs1_data,
    output logic [DATA_W-1:0]     out_rs2_data,
    output logic [DATA_W-1:0]     out_imm,
    output logic [DATA_W-1:0]     out_pc,
`ifdef DECODE_EXECUTE_STAGE_PERF_CNT_EN
    output logic [15:0]           stall_cnt,
    output logic [15:0]           bubble_cnt,
    output logic [15:0]           flush_cnt,
`endif
    output logic                  hazard
);

    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    logic              r_valid;
    ctrl_t             r_ctrl;
    logic [REG_AW-1:0] r_rs1;
    logic [REG_AW-1:0] r_rs2;
    logic [REG_AW-1:0] r_rd;
    logic [DATA_W-1:0] r_rs1Data;
    logic [DATA_W-1:0] r_rs2Data;
    logic [DATA_W-1:0] r_imm;
    logic [DATA_W-1:0] r_pc;

    ctrl_t             w_inCtrl;
    logic              w_advance;
    logic              w_hazard;

    load_use_hazard #(
        .REG_AW (REG_AW)
    ) u_hazard (
        .i_heldValid    (r_valid),
        .i_heldMemToReg (r_ctrl.mem_to_reg),
        .i_heldRd       (r_rd),
        .i_inValid      (in_valid),
        .i_inRs1        (in_rs1),
        .i_inRs2        (in_rs2),
        .i_inImmSrc     (in_imm_src),
        .o_hazard       (w_hazard)
    );

    // Handshake: the register may take a new entry when empty or draining
    always_comb begin
        w_inCtrl.imm_src     = in_imm_src;
        w_inCtrl.branch_flag = in_branch_flag;
        w_inCtrl.mem_write   = in_mem_write;
        w_inCtrl.mem_to_reg  = in_mem_to_reg;
        w_inCtrl.alu_control = in_alu_control;
        w_advance            = !r_valid || out_ready;
        in_ready             = w_advance && !w_hazard && !flush;
        hazard               = w_hazard;
    end

    // Pipeline register: reset > flush > advance (bubble on hazard); hold otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_ctrl    <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_rd      <= '0;
            r_rs1Data <= '0;
            r_rs2Data <= '0;
            r_imm     <= '0;
            r_pc      <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_advance) begin
            if (w_hazard) begin
                r_valid <= 1'b0;
            end else begin
                r_valid <= in_valid;
                if (in_valid) begin
                    r_ctrl    <= w_inCtrl;
                    r_rs1     <= in_rs1;
                    r_rs2     <= in_rs2;
                    r_rd      <= in_rd;
                    r_rs1Data <= in_rs1_data;
                    r_rs2Data <= in_rs2_data;
                    r_imm     <= in_imm;
                    r_pc      <= in_pc;
                end
            end
        end
    end

    // Output mapping; side-effecting controls are masked so a bubble is inert
    always_comb begin
        out_valid       = r_valid;
        out_imm_src     = r_ctrl.imm_src;
        out_branch_flag = r_ctrl.branch_flag && r_valid;
        out_mem_write   = r_ctrl.mem_write && r_valid;
        out_mem_to_reg  = r_ctrl.mem_to_reg;
        out_alu_control = r_ctrl.alu_control;
        out_rs1         = r_rs1;
        out_rs2         = r_rs2;
        out_rd          = r_rd;
        out_rs1_data    = r_rs1Data;
        out_rs2_data    = r_rs2Data;
        out_imm         = r_imm;
        out_pc          = r_pc;
    end

`ifdef DECODE_EXECUTE_STAGE_PERF_CNT_EN
    logic [15:0] r_stallCnt;
    logic [15:0] r_bubbleCnt;
    logic [15:0] r_flushCnt;
    logic        w_stallEvt;
    logic        w_bubbleEvt;

    // A bubble is only inserted when the hazard path actually wins the edge
    always_comb begin
        w_stallEvt  = in_valid && !in_ready;
        w_bubbleEvt = !flush && w_advance && w_hazard;
    end

    // Saturating event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stallCnt  <= '0;
            r_bubbleCnt <= '0;
            r_flushCnt  <= '0;
        end else begin
            if (w_stallEvt && (r_stallCnt != c_CNT_MAX))
                r_stallCnt <= r_stallCnt + 16'd1;
            if (w_bubbleEvt && (r_bubbleCnt != c_CNT_MAX))
                r_bubbleCnt <= r_bubbleCnt + 16'd1;
            if (flush && (r_flushCnt != c_CNT_MAX))
                r_flushCnt <= r_flushCnt + 16'd1;
        end
    end

    always_comb begin
        stall_cnt  = r_stallCnt;
        bubble_cnt = r_bubbleCnt;
        flush_cnt  = r_flushCnt;
    end
`endif

endmodule : decode_execute_stage
`default_nettype wire

// File: tb/tb_decode_execute_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_execute_stage
//  Description : Directed self-checking bench for decode_execute_stage.
//                Inputs change #1 after a rising edge; outputs are checked
//                in the same window, away from the clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_execute_stage;

    localparam int DATA_W = 32;
    localparam int REG_AW = 4;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic              in_imm_src;
    logic              in_branch_flag;
    logic              in_mem_write;
    logic              in_mem_to_reg;
    logic [3:0]        in_alu_control;
    logic [REG_AW-1:0] in_rs1;
    logic [REG_AW-1:0] in_rs2;
    logic [REG_AW-1:0] in_rd;
    logic [DATA_W-1:0] in_rs1_data;
    logic [DATA_W-1:0] in_rs2_data;
    logic [DATA_W-1:0] in_imm;
    logic [DATA_W-1:0] in_pc;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic              out_imm_src;
    logic              out_branch_flag;
    logic              out_mem_write;
    logic              out_mem_to_reg;
    logic [3:0]        out_alu_control;
    logic [REG_AW-1:0] out_rs1;
    logic [REG_AW-1:0] out_rs2;
    logic [REG_AW-1:0] out_rd;
    logic [DATA_W-1:0] out_rs1_data;
    logic [DATA_W-1:0] out_rs2_data;
    logic [DATA_W-1:0] out_imm;
    logic [DATA_W-1:0] out_pc;
    logic              hazard;
`ifdef DECODE_EXECUTE_STAGE_PERF_CNT_EN
    logic [15:0]       stall_cnt;
    logic [15:0]       bubble_cnt;
    logic [15:0]       flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    decode_execute_stage #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_imm_src      (in_imm_src),
        .in_branch_flag  (in_branch_flag),
        .in_mem_write    (in_mem_write),
        .in_mem_to_reg   (in_mem_to_reg),
        .in_alu_control  (in_alu_control),
        .in_rs1          (in_rs1),
        .in_rs2          (in_rs2),
        .in_rd           (in_rd),
        .in_rs1_data     (in_rs1_data),
        .in_rs2_data     (in_rs2_data),
        .in_imm          (in_imm),
        .in_pc           (in_pc),
        .flush           (flush),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_imm_src     (out_imm_src),
        .out_branch_flag (out_branch_flag),
        .out_mem_write   (out_mem_write),
        .out_mem_to_reg  (out_mem_to_reg),
        .out_alu_control (out_alu_control),
        .out_rs1         (out_rs1),
        .out_rs2         (out_rs2),
        .out_rd          (out_rd),
        .out_rs1_data    (out_rs1_data),
        .out_rs2_data    (out_rs2_data),
        .out_imm         (out_imm),
        .out_pc          (out_pc),
`ifdef DECODE_EXECUTE_STAGE_PERF_CNT_EN
        .stall_cnt       (stall_cnt),
        .bubble_cnt      (bubble_cnt),
        .flush_cnt       (flush_cnt),
`endif
        .hazard          (hazard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and land just past the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction on the decode side
    task automatic drive(input logic v, input logic immSrc, input logic br,
                         input logic mw, input logic m2r, input logic [3:0] alu,
                         input logic [3:0] rs1, input logic [3:0] rs2, input logic [3:0] rd,
                         input logic [31:0] imm, input logic [31:0] pc);
        in_valid       = v;
        in_imm_src     = immSrc;
        in_branch_flag = br;
        in_mem_write   = mw;
        in_mem_to_reg  = m2r;
        in_alu_control = alu;
        in_rs1         = rs1;
        in_rs2         = rs2;
        in_rd          = rd;
        in_rs1_data    = 32'hA000_0000 | pc;
        in_rs2_data    = 32'hB000_0000 | pc;
        in_imm         = imm;
        in_pc          = pc;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 32'd0, 32'd0);
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 4'd3, 4'd4, 4'd5, 32'hDEAD, 32'hBEEF);
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++;
        if ({out_imm_src, out_branch_flag, out_mem_write, out_mem_to_reg, out_alu_control,
             out_rs1, out_rs2, out_rd, out_rs1_data, out_rs2_data, out_imm, out_pc} !== '0) begin
            errors++; $display("FAIL reset_payload: got pc=%h imm=%h alu=%h rd=%h want all zero",
                               out_pc, out_imm, out_alu_control, out_rd);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        idle();
        tick();
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'(i), 4'd1, 4'd2, 4'(i + 1), 32'd0, 32'h100 + 32'(4 * i));
            #1;
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d]: got %b want 1", i, in_ready); end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_alu_control !== 4'(i) || out_rd !== 4'(i + 1) ||
                out_pc !== 32'h100 + 32'(4 * i)) begin
                errors++; $display("FAIL stream_out[%0d]: got v=%b alu=%h rd=%h pc=%h want v=1 alu=%h rd=%h pc=%h",
                                   i, out_valid, out_alu_control, out_rd, out_pc, i, i + 1, 32'h100 + 32'(4 * i));
            end
        end
        idle();
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_load_use();
        out_ready = 1'b1;
        // load x5, then add reading x5 through rs1
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd1, 4'd0, 4'd5, 32'd0, 32'h200);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 4'd5, 4'd6, 4'd7, 32'd0, 32'h204);
        #1;
        checks++;
        if (hazard !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL lu_detect: got hazard=%b ready=%b want 1/0", hazard, in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || hazard !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL lu_bubble: got v=%b hazard=%b ready=%b want 0/0/1", out_valid, hazard, in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h204 || out_alu_control !== 4'd2) begin
            errors++; $display("FAIL lu_emerge: got v=%b pc=%h alu=%h want 1/204/2", out_valid, out_pc, out_alu_control);
        end
        // load x5, then consumer reading x5 only through rs2 while immediate replaces rs2
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd1, 4'd0, 4'd5, 32'd0, 32'h210);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 4'd1, 4'd5, 4'd8, 32'd0, 32'h214);
        #1;
        checks++;
        if (hazard !== 1'b1) begin errors++; $display("FAIL lu_rs2_reg: got hazard=%b want 1", hazard); end
        in_imm_src = 1'b1;
        #1;
        checks++;
        if (hazard !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL lu_rs2_imm: got hazard=%b ready=%b want 0/1", hazard, in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h214) begin
            errors++; $display("FAIL lu_imm_pass: got v=%b pc=%h want 1/214", out_valid, out_pc);
        end
        // load to x0 never stalls
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd1, 4'd0, 4'd0, 32'd0, 32'h220);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd0, 4'd0, 4'd9, 32'd0, 32'h224);
        #1;
        checks++;
        if (hazard !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL lu_rd0: got hazard=%b ready=%b want 0/1", hazard, in_ready);
        end
        tick();
        idle();
        tick();
    endtask

    task automatic test_back_pressure();
        out_ready = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4, 4'd1, 4'd2, 4'd3, 32'h1234, 32'h300);
        tick();
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5, 4'd1, 4'd2, 4'd4, 32'h5678, 32'h304);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_imm !== 32'h1234 || out_pc !== 32'h300) begin
                errors++; $display("FAIL bp_hold[%0d]: got ready=%b v=%b imm=%h pc=%h want 0/1/1234/300",
                                   i, in_ready, out_valid, out_imm, out_pc);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_imm !== 32'h5678 || out_pc !== 32'h304) begin
            errors++; $display("FAIL bp_next: got v=%b imm=%h pc=%h want 1/5678/304", out_valid, out_imm, out_pc);
        end
        idle();
        tick();
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        // store held under back-pressure, then killed by a taken branch
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd6, 4'd1, 4'd2, 4'd0, 32'd0, 32'h400);
        tick();
        checks++;
        if (out_mem_write !== 1'b1 || out_branch_flag !== 1'b1) begin
            errors++; $display("FAIL flush_store_held: got mw=%b br=%b want 1/1", out_mem_write, out_branch_flag);
        end
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd7, 4'd1, 4'd2, 4'd3, 32'd0, 32'h404);
        flush = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", in_ready); end
        tick();
        flush = 1'b0;
        idle();
        out_ready = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_mem_write !== 1'b0 || out_branch_flag !== 1'b0) begin
            errors++; $display("FAIL flush_kill: got v=%b mw=%b br=%b want 0/0/0", out_valid, out_mem_write, out_branch_flag);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_not_accepted: got %b want 0", out_valid); end
        // flush coincident with a load-use hazard
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd1, 4'd0, 4'd6, 32'd0, 32'h410);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd6, 4'd1, 4'd7, 32'd0, 32'h414);
        flush = 1'b1;
        #1;
        checks++;
        if (hazard !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL flush_haz_comb: got hazard=%b ready=%b want 1/0", hazard, in_ready);
        end
        tick();
        flush = 1'b0;
        idle();
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_pc !== 32'h410) begin
            errors++; $display("FAIL flush_haz_wins: got v=%b pc=%h want 0/410", out_valid, out_pc);
        end
        tick();
    endtask

`ifdef DECODE_EXECUTE_STAGE_PERF_CNT_EN
    task automatic test_perf_counters();
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        idle();
        tick();
        rst = 1'b0;
        checks++;
        if (stall_cnt !== 16'd0 || bubble_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            errors++; $display("FAIL perf_reset: got s=%h b=%h f=%h want 0/0/0", stall_cnt, bubble_cnt, flush_cnt);
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd1, 4'd0, 4'd5, 32'd0, 32'h500);
            tick();
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 4'd5, 4'd1, 4'd7, 32'd0, 32'h504);
            tick();
            tick();
            idle();
        end
        flush = 1'b1;
        repeat (3) tick();
        flush = 1'b0;
        #1;
        checks++;
        if (bubble_cnt !== 16'd2 || flush_cnt !== 16'd3) begin
            errors++; $display("FAIL perf_counts: got b=%0d f=%0d want 2/3", bubble_cnt, flush_cnt);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd1, 4'd1, 4'd1, 32'd0, 32'h600);
        tick();
        out_ready = 1'b0;
        repeat (70000) tick();
        checks++;
        if (stall_cnt !== 16'hFFFF) begin
            errors++; $display("FAIL perf_stall_sat: got %h want ffff", stall_cnt);
        end
        out_ready = 1'b1;
        idle();
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_streaming();
        test_load_use();
        test_back_pressure();
        test_flush();
`ifdef DECODE_EXECUTE_STAGE_PERF_CNT_EN
        test_perf_counters();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule : tb_decode_execute_stage
`default_nettype wire
